// File: rtl/npu_host_seq.sv
// Host register interface and conv1 -> conv2 x CHAN -> FCN layer sequencer.
// Also holds the FC1 weight FIFO, the sticky status flags and the interrupt.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no job running; a GO starts conv1
// CONV1   | conv1 pass running, counting output pixels
// C2_WAIT | host loads channel ch data, then issues GO
// CONV2   | conv2 channel pass running, accumulating psums
// FCN     | waiting for the FCN result strobe
// DONE    | one-cycle completion state
module npu_host_seq #(
    parameter int CHAN     = 10,
    parameter int NUM_PE   = 4,
    parameter int N_PIX1   = 182,
    parameter int N_PIX2   = 132,
    parameter int WF_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_ni,
    input  logic                ena,
    input  logic                wea,
    input  logic [15:0]         addra,
    input  logic [31:0]         dina,
    output logic [31:0]         douta,
    output logic                conv_trigger,
    output logic                conv_layer,
    output logic                conv_clear,
    input  logic                conv_pix_valid,
    output logic                psum_clear,
    output logic                fcn_start,
    output logic [8*NUM_PE-1:0] fcn_w,
    output logic                fcn_w_valid,
    input  logic                fcn_w_ready,
    input  logic                fcn_done,
    input  logic [23:0]         fcn_logit,
    output logic                irq
);
    localparam int PIX_MAX = (N_PIX1 > N_PIX2) ? N_PIX1 : N_PIX2;
    localparam int PIX_W   = $clog2(PIX_MAX + 1);
    localparam int CH_W    = $clog2(CHAN + 1);
    localparam int AW      = $clog2(WF_DEPTH);
    localparam int FW      = 8 * NUM_PE;
    localparam logic [PIX_W-1:0] PIX1_LAST = PIX_W'(N_PIX1 - 1);
    localparam logic [PIX_W-1:0] PIX2_LAST = PIX_W'(N_PIX2 - 1);
    localparam logic [CH_W-1:0]  CHAN_L    = CH_W'(CHAN);
    localparam logic [AW:0]      WF_FULL   = (AW + 1)'(WF_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CONV1   = 3'd1,
        S_C2_WAIT = 3'd2,
        S_CONV2   = 3'd3,
        S_FCN     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [PIX_W-1:0]  r_pix;
    logic [CH_W-1:0]   r_ch, w_ch_nxt, w_ch_inc;
    logic              r_conv_trigger, r_conv_layer, r_conv_clear, r_psum_clear, r_fcn_start;
    logic              w_trig, w_layer_nxt, w_cclr, w_pclr, w_fstart;
    logic              r_done, r_err_ovf, r_err_cmd, r_irq_en;
    logic              w_done_set, w_cmd_err, w_ovf;
    logic [23:0]       r_logit;
    logic [31:0]       r_douta, w_rdata;
    logic [FW-1:0]     r_wf_mem [WF_DEPTH];
    logic [AW-1:0]     r_wf_wptr, r_wf_rptr;
    logic [AW:0]       r_wf_cnt;

    logic [2:0]  w_sel;
    logic [11:0] w_idx;
    logic        w_wr, w_rd, w_ctrl_wr, w_go, w_abort, w_w1c, w_push;
    logic        w_busy, w_wf_full, w_wf_empty, w_pop, w_push_ok;
    logic        w_pix1_last, w_pix2_last;

    assign w_sel     = addra[14:12];
    assign w_idx     = addra[11:0];
    assign w_wr      = ena & wea;
    assign w_rd      = ena & ~wea;
    assign w_ctrl_wr = w_wr && (w_sel == 3'd5) && (w_idx == 12'd0);
    assign w_abort   = w_ctrl_wr & dina[1];
    assign w_go      = w_ctrl_wr & dina[0] & ~dina[1];
    assign w_w1c     = w_wr && (w_sel == 3'd7) && (w_idx == 12'd0);
    assign w_push    = w_wr && (w_sel == 3'd3);

    assign w_busy      = (r_state != S_IDLE);
    assign w_pix1_last = conv_pix_valid && (r_pix == PIX1_LAST);
    assign w_pix2_last = conv_pix_valid && (r_pix == PIX2_LAST);
    assign w_ch_inc    = r_ch + 1'b1;

    assign w_wf_full  = (r_wf_cnt == WF_FULL);
    assign w_wf_empty = (r_wf_cnt == '0);
    assign w_pop      = ~w_wf_empty & fcn_w_ready;
    assign w_push_ok  = w_push & (~w_wf_full | w_pop);
    assign w_ovf      = w_push & w_wf_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= S_IDLE;
            r_ch           <= '0;
            r_conv_trigger <= 1'b0;
            r_conv_layer   <= 1'b0;
            r_conv_clear   <= 1'b0;
            r_psum_clear   <= 1'b0;
            r_fcn_start    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_ch           <= w_ch_nxt;
            r_conv_trigger <= w_trig;
            r_conv_layer   <= w_layer_nxt;
            r_conv_clear   <= w_cclr;
            r_psum_clear   <= w_pclr;
            r_fcn_start    <= w_fstart;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_layer_nxt = r_conv_layer;
        w_trig      = 1'b0;
        w_cclr      = 1'b0;
        w_pclr      = 1'b0;
        w_fstart    = 1'b0;
        w_done_set  = 1'b0;
        w_cmd_err   = 1'b0;
        if (w_abort) begin
            // An abort in IDLE only flushes the FIFO; no clear pulses.
            if (r_state != S_IDLE) begin
                w_state_nxt = S_IDLE;
                w_cclr      = 1'b1;
                w_pclr      = 1'b1;
                w_ch_nxt    = '0;
                w_layer_nxt = 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        w_state_nxt = S_CONV1;
                        w_trig      = 1'b1;
                        w_layer_nxt = 1'b0;
                    end
                end
                S_CONV1: begin
                    w_cmd_err = w_go;
                    if (w_pix1_last) begin
                        w_state_nxt = S_C2_WAIT;
                        w_cclr      = 1'b1;
                        w_pclr      = 1'b1;
                        w_ch_nxt    = '0;
                        w_layer_nxt = 1'b1;
                    end
                end
                S_C2_WAIT: begin
                    if (w_go) begin
                        w_state_nxt = S_CONV2;
                        w_trig      = 1'b1;
                    end
                end
                S_CONV2: begin
                    w_cmd_err = w_go;
                    if (w_pix2_last) begin
                        w_cclr   = 1'b1;
                        w_ch_nxt = w_ch_inc;
                        if (w_ch_inc == CHAN_L) begin
                            w_state_nxt = S_FCN;
                            w_layer_nxt = 1'b0;
                            w_fstart    = 1'b1;
                        end else begin
                            w_state_nxt = S_C2_WAIT;
                        end
                    end
                end
                S_FCN: begin
                    w_cmd_err = w_go;
                    if (fcn_done) begin
                        w_state_nxt = S_DONE;
                        w_done_set  = 1'b1;
                    end
                end
                S_DONE: begin
                    w_cmd_err   = w_go;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Pixel counter restarts on every state change.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pix <= '0;
        end else if (w_state_nxt != r_state) begin
            r_pix <= '0;
        end else if (conv_pix_valid && (r_state == S_CONV1 || r_state == S_CONV2)) begin
            r_pix <= r_pix + 1'b1;
        end
    end

    // Sticky flags: a set in the same cycle as a W1C wins.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_done    <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_cmd <= 1'b0;
            r_irq_en  <= 1'b0;
            r_logit   <= '0;
        end else begin
            r_done    <= w_done_set | (r_done    & ~(w_w1c & dina[0]));
            r_err_ovf <= w_ovf      | (r_err_ovf & ~(w_w1c & dina[1]));
            r_err_cmd <= w_cmd_err  | (r_err_cmd & ~(w_w1c & dina[2]));
            if (w_ctrl_wr)  r_irq_en <= dina[2];
            if (w_done_set) r_logit  <= fcn_logit;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wf_wptr <= '0;
            r_wf_rptr <= '0;
            r_wf_cnt  <= '0;
            for (int i = 0; i < WF_DEPTH; i++) r_wf_mem[i] <= '0;
        end else if (w_abort) begin
            r_wf_wptr <= '0;
            r_wf_rptr <= '0;
            r_wf_cnt  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wf_mem[r_wf_wptr] <= dina[FW-1:0];
                r_wf_wptr           <= r_wf_wptr + 1'b1;
            end
            if (w_pop) r_wf_rptr <= r_wf_rptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_wf_cnt <= r_wf_cnt + 1'b1;
                2'b01:   r_wf_cnt <= r_wf_cnt - 1'b1;
                default: r_wf_cnt <= r_wf_cnt;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_sel == 3'd7) begin
            case (w_idx)
                12'd0:   w_rdata = {25'b0, 3'(r_state), r_err_cmd, r_err_ovf, w_busy, r_done};
                12'd4:   w_rdata = {{8{r_logit[23]}}, r_logit};
                12'd8:   w_rdata = 32'(r_ch);
                12'd12:  w_rdata = 32'(r_wf_cnt);
                default: w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_douta <= '0;
        end else if (w_rd) begin
            r_douta <= w_rdata;
        end
    end

    assign douta        = r_douta;
    assign conv_trigger = r_conv_trigger;
    assign conv_layer   = r_conv_layer;
    assign conv_clear   = r_conv_clear;
    assign psum_clear   = r_psum_clear;
    assign fcn_start    = r_fcn_start;
    assign fcn_w        = r_wf_mem[r_wf_rptr];
    assign fcn_w_valid  = ~w_wf_empty;
    assign irq          = r_done & r_irq_en;
endmodule

// File: tb/tb_npu_host_seq.sv
// Directed bench for npu_host_seq with CHAN=2: job sequencing, irq,
// weight FIFO, abort and reset behaviour against hand-computed values.
module tb_npu_host_seq;
    localparam int CHAN = 2;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        ena, wea;
    logic [15:0] addra;
    logic [31:0] dina, douta;
    logic        conv_trigger, conv_layer, conv_clear, conv_pix_valid;
    logic        psum_clear, fcn_start;
    logic [31:0] fcn_w;
    logic        fcn_w_valid, fcn_w_ready, fcn_done, irq;
    logic [23:0] fcn_logit;

    int n_tests = 0;
    int n_fail  = 0;
    int n_trig = 0, n_cclr = 0, n_pclr = 0, n_fstart = 0;
    int s_trig, s_cclr, s_pclr, s_fstart;
    logic [31:0] rd;

    npu_host_seq #(.CHAN(CHAN), .NUM_PE(4), .N_PIX1(182), .N_PIX2(132), .WF_DEPTH(8)) u_dut (
        .clk(clk), .rst_ni(rst_ni), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta), .conv_trigger(conv_trigger), .conv_layer(conv_layer),
        .conv_clear(conv_clear), .conv_pix_valid(conv_pix_valid), .psum_clear(psum_clear),
        .fcn_start(fcn_start), .fcn_w(fcn_w), .fcn_w_valid(fcn_w_valid),
        .fcn_w_ready(fcn_w_ready), .fcn_done(fcn_done), .fcn_logit(fcn_logit), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_ni) begin
            if (conv_trigger) n_trig++;
            if (conv_clear)   n_cclr++;
            if (psum_clear)   n_pclr++;
            if (fcn_start)    n_fstart++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [2:0] sel, input logic [11:0] idx, input logic [31:0] d);
        ena = 1'b1; wea = 1'b1; addra = {1'b0, sel, idx}; dina = d;
        tick();
        ena = 1'b0; wea = 1'b0; addra = '0; dina = '0;
    endtask

    task automatic host_read(input logic [2:0] sel, input logic [11:0] idx, output logic [31:0] d);
        ena = 1'b1; wea = 1'b0; addra = {1'b0, sel, idx};
        tick();
        ena = 1'b0; addra = '0;
        d = douta;
    endtask

    task automatic strobes(input int n);
        conv_pix_valid = 1'b1;
        repeat (n) tick();
        conv_pix_valid = 1'b0;
    endtask

    task automatic snap();
        s_trig = n_trig; s_cclr = n_cclr; s_pclr = n_pclr; s_fstart = n_fstart;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; ena = 1'b0; wea = 1'b0; addra = '0; dina = '0;
        conv_pix_valid = 1'b0; fcn_w_ready = 1'b0; fcn_done = 1'b0; fcn_logit = '0;
        repeat (3) tick();
        check("rst_trig",  32'(conv_trigger), 32'd0);
        check("rst_layer", 32'(conv_layer),   32'd0);
        check("rst_valid", 32'(fcn_w_valid),  32'd0);
        check("rst_irq",   32'(irq),          32'd0);
        check("rst_douta", douta,             32'd0);
        rst_ni = 1'b1;
        tick();
        host_read(3'd7, 12'd0, rd);   check("rst_status", rd, 32'h0);

        // Full job with an illegal GO during conv1
        snap();
        host_write(3'd5, 12'd0, 32'h1);
        check("go_trig", 32'(conv_trigger), 32'd1);
        host_read(3'd7, 12'd0, rd);   check("conv1_status", rd, 32'h12);
        strobes(100);
        host_write(3'd5, 12'd0, 32'h1);
        strobes(81);
        host_read(3'd7, 12'd0, rd);   check("go_in_conv1_status", rd, 32'h1A);
        strobes(1);
        check("conv1_end_cclr",  32'(conv_clear), 32'd1);
        check("conv1_end_pclr",  32'(psum_clear), 32'd1);
        check("conv1_end_layer", 32'(conv_layer), 32'd1);
        host_read(3'd7, 12'd0, rd);   check("c2wait_status", rd, 32'h2A);
        host_write(3'd7, 12'd0, 32'h4);
        host_write(3'd5, 12'd0, 32'h1);
        host_read(3'd7, 12'd8, rd);   check("ch0", rd, 32'd0);
        strobes(132);
        host_read(3'd7, 12'd8, rd);   check("ch1", rd, 32'd1);
        host_read(3'd7, 12'd0, rd);   check("c2wait2_status", rd, 32'h22);
        host_write(3'd5, 12'd0, 32'h1);
        strobes(132);
        check("fcn_start_pulse", 32'(fcn_start),  32'd1);
        check("fcn_layer",       32'(conv_layer), 32'd0);
        host_read(3'd7, 12'd0, rd);   check("fcn_status", rd, 32'h42);
        fcn_done = 1'b1; fcn_logit = 24'hFFFFFB;
        tick();
        fcn_done = 1'b0; fcn_logit = '0;
        tick();
        host_read(3'd7, 12'd4, rd);   check("logit_neg5", rd, 32'hFFFFFFFB);
        host_read(3'd7, 12'd0, rd);   check("done_status", rd, 32'h01);
        check("job_trig_cnt",   32'(n_trig - s_trig),     32'd3);
        check("job_cclr_cnt",   32'(n_cclr - s_cclr),     32'd3);
        check("job_pclr_cnt",   32'(n_pclr - s_pclr),     32'd1);
        check("job_fstart_cnt", 32'(n_fstart - s_fstart), 32'd1);
        fcn_done = 1'b1; fcn_logit = 24'h000007;
        tick();
        fcn_done = 1'b0; fcn_logit = '0;
        host_read(3'd7, 12'd4, rd);   check("fcn_done_idle_ignored", rd, 32'hFFFFFFFB);

        // Interrupt
        host_write(3'd7, 12'd0, 32'h1);
        check("irq_pre", 32'(irq), 32'd0);
        host_write(3'd5, 12'd0, 32'h5);
        strobes(182);
        host_write(3'd5, 12'd0, 32'h5);
        strobes(132);
        host_write(3'd5, 12'd0, 32'h5);
        strobes(132);
        check("irq_before_done", 32'(irq), 32'd0);
        fcn_done = 1'b1; fcn_logit = 24'h000123;
        tick();
        fcn_done = 1'b0; fcn_logit = '0;
        check("irq_high", 32'(irq), 32'd1);
        repeat (3) tick();
        check("irq_held", 32'(irq), 32'd1);
        host_write(3'd7, 12'd0, 32'h1);
        check("irq_cleared", 32'(irq), 32'd0);
        host_read(3'd7, 12'd4, rd);   check("logit_pos", rd, 32'h00000123);

        // FIFO overflow and ordered drain
        for (int k = 0; k < 9; k++) host_write(3'd3, 12'd0, 32'h11111111 * (k + 1));
        host_read(3'd7, 12'd12, rd);  check("fifo_cnt_full", rd, 32'd8);
        host_read(3'd7, 12'd0, rd);   check("ovf_status", rd, 32'h04);
        check("fifo_valid", 32'(fcn_w_valid), 32'd1);
        fcn_w_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("fifo_out%0d", k), fcn_w, 32'h11111111 * (k + 1));
            tick();
        end
        fcn_w_ready = 1'b0;
        check("fifo_drained", 32'(fcn_w_valid), 32'd0);
        host_write(3'd7, 12'd0, 32'h2);

        // Push and pop together while full
        for (int k = 0; k < 8; k++) host_write(3'd3, 12'd0, 32'hA0000000 + k);
        fcn_w_ready = 1'b1;
        host_write(3'd3, 12'd0, 32'hB0000000);
        fcn_w_ready = 1'b0;
        host_read(3'd7, 12'd12, rd);  check("pushpop_cnt", rd, 32'd8);
        host_read(3'd7, 12'd0, rd);   check("pushpop_no_ovf", rd, 32'h0);
        check("pushpop_head", fcn_w, 32'hA0000001);

        // Abort during conv2 with ch=1
        host_write(3'd5, 12'd0, 32'h1);
        strobes(182);
        host_write(3'd5, 12'd0, 32'h1);
        strobes(132);
        host_write(3'd5, 12'd0, 32'h1);
        strobes(10);
        snap();
        host_write(3'd5, 12'd0, 32'h2);
        check("abort_cclr",  32'(conv_clear), 32'd1);
        check("abort_pclr",  32'(psum_clear), 32'd1);
        check("abort_layer", 32'(conv_layer), 32'd0);
        check("abort_flush", 32'(fcn_w_valid), 32'd0);
        tick();
        check("abort_cclr_one", 32'(conv_clear), 32'd0);
        host_read(3'd7, 12'd0, rd);   check("abort_status", rd, 32'h0);
        host_read(3'd7, 12'd8, rd);   check("abort_ch", rd, 32'd0);
        host_read(3'd7, 12'd12, rd);  check("abort_cnt", rd, 32'd0);

        // GO and ABORT together in IDLE
        host_write(3'd3, 12'd0, 32'h12345678);
        snap();
        host_write(3'd5, 12'd0, 32'h3);
        tick();
        host_read(3'd7, 12'd0, rd);   check("goabort_status", rd, 32'h0);
        host_read(3'd7, 12'd12, rd);  check("goabort_flush", rd, 32'd0);
        check("goabort_no_pulse", 32'((n_trig - s_trig) + (n_cclr - s_cclr) + (n_pclr - s_pclr)), 32'd0);

        // Asynchronous reset mid-job
        host_write(3'd5, 12'd0, 32'h1);
        strobes(182);
        host_write(3'd3, 12'd0, 32'hCAFEF00D);
        host_write(3'd5, 12'd0, 32'h1);
        strobes(5);
        snap();
        rst_ni = 1'b0;
        #1;
        check("midrst_layer", 32'(conv_layer),  32'd0);
        check("midrst_valid", 32'(fcn_w_valid), 32'd0);
        #2;
        rst_ni = 1'b1;
        tick();
        check("midrst_no_pulse", 32'((n_trig - s_trig) + (n_cclr - s_cclr) + (n_pclr - s_pclr)), 32'd0);
        host_read(3'd7, 12'd0, rd);   check("midrst_status", rd, 32'h0);
        host_read(3'd7, 12'd8, rd);   check("midrst_ch", rd, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
